game_ctrl: RTL and testbench

- Upstream stage of the renderer. Conditions the raw start and flap push-buttons and runs the game-level FSM (idle, arm, play, over).
- Drives the renderer's `reset`, `game_start` and `flap` inputs, and consumes its `lose` output.
- Stretches each flap press so the slow physics domain (60 Hz) is guaranteed to sample it.
- Counts games played.

---
 rtl/game_pkg.sv | 21 ++
 rtl/game_ctrl_if.sv | 26 ++
 rtl/btn_debounce.sv | 57 +++++
 rtl/game_ctrl.sv | 143 ++++++++++++++
 tb/tb_game_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default timing for the game controller
package game_pkg;

  // Game-level FSM states as seen on state_o
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } game_state_t;

  // Default timing at 100 MHz
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int unsigned DEF_FLAP_HOLD_CYCLES    = 2_000_000;
  localparam int unsigned DEF_OVER_LOCKOUT_CYCLES = 50_000_000;
  localparam int unsigned DEF_RST_PULSE_CYCLES    = 4;

  // Games counter saturates here rather than wrapping
  localparam logic [7:0] GAME_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - button, renderer and status signals of the game controller
interface game_ctrl_if;
  import game_pkg::*;

  logic        btn_start;
  logic        btn_flap;
  logic        lose;
  logic        play_reset;
  logic        game_start;
  logic        flap;
  game_state_t state_o;
  logic [7:0]  game_count;

  // Environment side: drives buttons and the renderer's lose flag
  modport master (
    output btn_start, btn_flap, lose,
    input  play_reset, game_start, flap, state_o, game_count
  );

  // Controller side
  modport slave (
    input  btn_start, btn_flap, lose,
    output play_reset, game_start, flap, state_o, game_count
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability debounce and rising-edge press strobe
module btn_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count how long the synchronized input has disagreed with the debounced level
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
  end

  // State registers, all cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - button conditioning, game FSM, flap stretcher and games counter
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned FLAP_HOLD_CYCLES    = DEF_FLAP_HOLD_CYCLES,
  parameter int unsigned OVER_LOCKOUT_CYCLES = DEF_OVER_LOCKOUT_CYCLES,
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  game_ctrl_if.slave bus
);

  localparam int unsigned HW = $clog2(FLAP_HOLD_CYCLES + 1);
  localparam int unsigned LW = $clog2(OVER_LOCKOUT_CYCLES + 1);
  localparam int unsigned RW = $clog2(RST_PULSE_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LOAD = HW'(FLAP_HOLD_CYCLES);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(OVER_LOCKOUT_CYCLES);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_PULSE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_ARM  = 2'(ARM);
  localparam logic [1:0] ST_PLAY = 2'(PLAY);
  localparam logic [1:0] ST_OVER = 2'(OVER);

  logic          start_press;
  logic          flap_press;
  logic [1:0]    state_q, state_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    count_q, count_d;
  logic          play_reset_q, play_reset_d;
  logic          game_start_q, game_start_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_db (
    .clk     (clk_100MHz),
    .reset   (reset),
    .btn_raw (bus.btn_start),
    .press   (start_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_flap_db (
    .clk     (clk_100MHz),
    .reset   (reset),
    .btn_raw (bus.btn_flap),
    .press   (flap_press)
  );

  // Game FSM with its reset-pulse, lockout, flap-hold and games counters
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    count_d    = count_q;
    case (state_q)
      ST_IDLE: begin
        rst_cnt_d  = '0;
        hold_cnt_d = '0;
        // A flap press arriving with start is simply not looked at here
        if (start_press) begin
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        // lose is not looked at: the renderer is still being cleared
        hold_cnt_d = '0;
        if (rst_cnt_q == RST_LAST) begin
          state_d   = ST_PLAY;
          rst_cnt_d = '0;
          if (count_q != GAME_COUNT_MAX) begin
            count_d = count_q + 8'd1;
          end
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      ST_PLAY: begin
        // Collision beats a simultaneous flap and kills any running pulse
        if (bus.lose) begin
          state_d    = ST_OVER;
          lock_cnt_d = LOCK_LOAD;
          hold_cnt_d = '0;
        end else if (flap_press) begin
          hold_cnt_d = HOLD_LOAD;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: begin
        // OVER: a press seen during lockout is dropped, never remembered
        hold_cnt_d = '0;
        if (start_press && (lock_cnt_q == '0)) begin
          state_d   = ST_ARM;
          rst_cnt_d = '0;
        end else if (lock_cnt_q != '0) begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
    endcase
  end

  // Renderer controls follow the next state so they line up with state_o
  always_comb begin
    play_reset_d = (state_d == ST_IDLE) || (state_d == ST_ARM);
    game_start_d = (state_d == ST_PLAY) || (state_d == ST_OVER);
  end

  // State and output registers
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rst_cnt_q    <= '0;
      lock_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      count_q      <= '0;
      play_reset_q <= 1'b1;
      game_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      count_q      <= count_d;
      play_reset_q <= play_reset_d;
      game_start_q <= game_start_d;
    end
  end

  assign bus.play_reset = play_reset_q;
  assign bus.game_start = game_start_q;
  assign bus.flap       = (hold_cnt_q != '0);
  assign bus.state_o    = game_state_t'(state_q);
  assign bus.game_count = count_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scenario and randomized model-checked bench for game_ctrl
module tb_game_ctrl;

  localparam int DEB   = 4;
  localparam int HOLD  = 3;
  localparam int LOCK  = 10;
  localparam int RST   = 2;
  localparam int HOLD2 = 12;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  game_ctrl_if bus ();
  game_ctrl_if bus2 ();

  game_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .FLAP_HOLD_CYCLES(HOLD),
    .OVER_LOCKOUT_CYCLES(LOCK), .RST_PULSE_CYCLES(RST)
  ) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  // Long flap hold so a second debounced press can land inside a running pulse
  game_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .FLAP_HOLD_CYCLES(HOLD2),
    .OVER_LOCKOUT_CYCLES(LOCK), .RST_PULSE_CYCLES(RST)
  ) dut2 (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus2)
  );

  always #5 clk = ~clk;

  // Reference model of dut: raw sample history per button, game phase, timers
  bit hist [2][16];
  bit lvl  [2];
  bit prs  [2];
  int m_phase   = 0;
  int arm_left  = 0;
  int lock_left = 0;
  int flap_left = 0;
  int games     = 0;

  task automatic model_edge();
    bit sp, fp, all_diff;
    bit raw [2];
    sp = prs[0];
    fp = prs[1];
    raw[0] = bus.btn_start;
    raw[1] = bus.btn_flap;
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 16; k++) hist[b][k] = 1'b0;
        lvl[b] = 1'b0;
        prs[b] = 1'b0;
      end
      m_phase = 0; arm_left = 0; lock_left = 0; flap_left = 0; games = 0;
      return;
    end
    // Level flips once the 2-cycle-delayed input held the other value DEB samples in a row
    for (int b = 0; b < 2; b++) begin
      for (int k = 15; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = raw[b];
      all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) if (hist[b][k] == lvl[b]) all_diff = 1'b0;
      prs[b] = 1'b0;
      if (all_diff) begin
        lvl[b] = ~lvl[b];
        prs[b] = lvl[b];
      end
    end
    case (m_phase)
      0: if (sp) begin m_phase = 1; arm_left = RST; end
      1: begin
        arm_left--;
        if (arm_left == 0) begin
          m_phase = 2;
          if (games < 255) games++;
        end
      end
      2: begin
        if (bus.lose) begin m_phase = 3; lock_left = LOCK; flap_left = 0; end
        else if (fp) flap_left = HOLD;
        else if (flap_left > 0) flap_left--;
      end
      default: begin
        if (sp && lock_left == 0) begin m_phase = 1; arm_left = RST; end
        else if (lock_left > 0) lock_left--;
      end
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    checks++; if (bus.play_reset !== 1'b1) begin errors++; $display("FAIL rst_play_reset got %0b exp 1", bus.play_reset); end
    checks++; if (bus.game_start !== 1'b0) begin errors++; $display("FAIL rst_game_start got %0b exp 0", bus.game_start); end
    checks++; if (bus.flap !== 1'b0) begin errors++; $display("FAIL rst_flap got %0b exp 0", bus.flap); end
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", bus.state_o); end
    checks++; if (bus.game_count !== 8'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.game_count); end
    bus.btn_start = 1'b1;
    repeat (2) step();
    bus.btn_start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL glitch_state[%0d] got %0d exp 0", i, bus.state_o); end
    end
  endtask

  task automatic test_start();
    bus.btn_start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL start_wait[%0d] got %0d exp 0", i, bus.state_o); end
    end
    step();
    checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL arm_entry got %0d exp 1", bus.state_o); end
    checks++; if (bus.play_reset !== 1'b1) begin errors++; $display("FAIL arm_play_reset got %0b exp 1", bus.play_reset); end
    step();
    checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL arm_hold got %0d exp 1", bus.state_o); end
    step();
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL play_entry got %0d exp 2", bus.state_o); end
    checks++; if (bus.play_reset !== 1'b0) begin errors++; $display("FAIL play_play_reset got %0b exp 0", bus.play_reset); end
    checks++; if (bus.game_start !== 1'b1) begin errors++; $display("FAIL play_game_start got %0b exp 1", bus.game_start); end
    checks++; if (bus.game_count !== 8'd1) begin errors++; $display("FAIL play_count got %0d exp 1", bus.game_count); end
    bus.btn_start = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_flap();
    bit exp_f;
    bus.btn_flap = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 8) bus.btn_flap = 1'b0;
      exp_f = (i >= 7 && i <= 9);
      checks++; if (bus.flap !== exp_f) begin errors++; $display("FAIL flap_single[%0d] got %0b exp %0b", i, bus.flap, exp_f); end
    end
    repeat (6) step();
  endtask

  task automatic test_over();
    bus.btn_flap = 1'b1;
    repeat (6) step();
    bus.lose = 1'b1;
    bus.btn_start = 1'b1;
    step();
    checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL lose_state got %0d exp 3", bus.state_o); end
    checks++; if (bus.flap !== 1'b0) begin errors++; $display("FAIL lose_flap got %0b exp 0", bus.flap); end
    checks++; if (bus.game_start !== 1'b1) begin errors++; $display("FAIL lose_game_start got %0b exp 1", bus.game_start); end
    checks++; if (bus.play_reset !== 1'b0) begin errors++; $display("FAIL lose_play_reset got %0b exp 0", bus.play_reset); end
    bus.lose = 1'b0;
    bus.btn_flap = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL over_held[%0d] got %0d exp 3", i, bus.state_o); end
      checks++; if (bus.flap !== 1'b0) begin errors++; $display("FAIL over_flap[%0d] got %0b exp 0", i, bus.flap); end
    end
    bus.btn_start = 1'b0;
    repeat (8) step();
    bus.btn_start = 1'b1;
    repeat (6) step();
    checks++; if (bus.state_o !== 2'd3) begin errors++; $display("FAIL repress_wait got %0d exp 3", bus.state_o); end
    step();
    checks++; if (bus.state_o !== 2'd1) begin errors++; $display("FAIL rearm_state got %0d exp 1", bus.state_o); end
    checks++; if (bus.play_reset !== 1'b1) begin errors++; $display("FAIL rearm_pr0 got %0b exp 1", bus.play_reset); end
    step();
    checks++; if (bus.play_reset !== 1'b1) begin errors++; $display("FAIL rearm_pr1 got %0b exp 1", bus.play_reset); end
    step();
    checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL replay_state got %0d exp 2", bus.state_o); end
    checks++; if (bus.play_reset !== 1'b0) begin errors++; $display("FAIL replay_pr got %0b exp 0", bus.play_reset); end
    checks++; if (bus.game_count !== 8'd2) begin errors++; $display("FAIL replay_count got %0d exp 2", bus.game_count); end
    bus.btn_start = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_retrigger();
    bit exp_f;
    bus2.btn_start = 1'b1;
    repeat (9) step();
    checks++; if (bus2.state_o !== 2'd2) begin errors++; $display("FAIL rt_play got %0d exp 2", bus2.state_o); end
    bus2.btn_start = 1'b0;
    repeat (8) step();
    bus2.btn_flap = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 5)  bus2.btn_flap = 1'b0;
      if (i == 11) bus2.btn_flap = 1'b1;
      if (i == 20) bus2.btn_flap = 1'b0;
      exp_f = (i >= 7 && i <= 29);
      checks++; if (bus2.flap !== exp_f) begin errors++; $display("FAIL rt_flap[%0d] got %0b exp %0b", i, bus2.flap, exp_f); end
    end
  endtask

  task automatic test_saturate();
    int exp_c;
    for (int g = 0; g < 256; g++) begin
      bus.lose = 1'b1;
      step();
      bus.lose = 1'b0;
      repeat (LOCK) step();
      bus.btn_start = 1'b1;
      repeat (10) step();
      bus.btn_start = 1'b0;
      repeat (7) step();
      exp_c = (3 + g > 255) ? 255 : 3 + g;
      if (g >= 250) begin
        checks++; if (bus.game_count !== 8'(exp_c)) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", g, bus.game_count, exp_c); end
        checks++; if (bus.state_o !== 2'd2) begin errors++; $display("FAIL sat_state[%0d] got %0d exp 2", g, bus.state_o); end
      end
    end
  endtask

  task automatic test_reset_mid_play();
    bus.btn_flap = 1'b1;
    repeat (8) step();
    checks++; if (bus.flap !== 1'b1) begin errors++; $display("FAIL mid_flap_active got %0b exp 1", bus.flap); end
    reset = 1'b1;
    step();
    checks++; if (bus.state_o !== 2'd0) begin errors++; $display("FAIL mid_rst_state got %0d exp 0", bus.state_o); end
    checks++; if (bus.flap !== 1'b0) begin errors++; $display("FAIL mid_rst_flap got %0b exp 0", bus.flap); end
    checks++; if (bus.game_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", bus.game_count); end
    checks++; if (bus.play_reset !== 1'b1) begin errors++; $display("FAIL mid_rst_pr got %0b exp 1", bus.play_reset); end
    reset = 1'b0;
    bus.btn_flap = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_random();
    int seg_s = 0;
    int seg_f = 0;
    int err0;
    bit exp_pr, exp_gs, exp_fl;
    err0 = errors;
    for (int i = 0; i < 4000 && (errors - err0) < 20; i++) begin
      if (seg_s == 0) begin bus.btn_start = 1'($urandom_range(0, 1)); seg_s = $urandom_range(1, 14); end
      if (seg_f == 0) begin bus.btn_flap = 1'($urandom_range(0, 1)); seg_f = $urandom_range(1, 14); end
      seg_s--;
      seg_f--;
      bus.lose = ($urandom_range(0, 11) == 0);
      reset = (i == 2000);
      step();
      exp_pr = (m_phase <= 1);
      exp_gs = (m_phase >= 2);
      exp_fl = (flap_left != 0);
      checks++; if (bus.state_o !== 2'(m_phase)) begin errors++; $display("FAIL rnd_state[%0d] got %0d exp %0d", i, bus.state_o, m_phase); end
      checks++; if (bus.play_reset !== exp_pr) begin errors++; $display("FAIL rnd_play_reset[%0d] got %0b exp %0b", i, bus.play_reset, exp_pr); end
      checks++; if (bus.game_start !== exp_gs) begin errors++; $display("FAIL rnd_game_start[%0d] got %0b exp %0b", i, bus.game_start, exp_gs); end
      checks++; if (bus.flap !== exp_fl) begin errors++; $display("FAIL rnd_flap[%0d] got %0b exp %0b", i, bus.flap, exp_fl); end
      checks++; if (bus.game_count !== 8'(games)) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, bus.game_count, games); end
    end
    reset = 1'b0;
    bus.lose = 1'b0;
    bus.btn_start = 1'b0;
    bus.btn_flap = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.btn_start  = 1'b0;
    bus.btn_flap   = 1'b0;
    bus.lose       = 1'b0;
    bus2.btn_start = 1'b0;
    bus2.btn_flap  = 1'b0;
    bus2.lose      = 1'b0;
    test_reset();
    test_start();
    test_flap();
    test_over();
    test_retrigger();
    test_saturate();
    test_reset_mid_play();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
